cr16_decode_fsm: RTL and testbench
==================================

CR16_DECODE_FSM -- requirements
Module: cr16_decode_fsm

Interface
REQ-001 SHALL have port I_CLK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port I_RESET, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port I_ENABLE, input, 1 bit: 1 lets the FSM advance, 0 stalls it.
REQ-004 SHALL have port I_INSTR_VALID, input, 1 bit: the instruction source has a word on I_INSTR.
REQ-005 SHALL have port I_INSTR, input, 16 bits: instruction word; [15:12] opcode, [11:8] Rdest, [7] IMM flag, [3:0] Rsrc, [6:0] imm7.
REQ-006 SHALL have port I_STATUS_FLAGS, input, 5 bits: datapath status flags.
REQ-007 SHALL have port O_INSTR_READY, output, 1 bit: the block accepts I_INSTR this cycle.
REQ-008 SHALL have port O_REG_WRITE_ENABLE, output, 16 bits: one-hot register-file write strobe to the datapath.
REQ-009 SHALL have ports O_REG_A_SELECT and O_REG_B_SELECT, outputs, 4 bits each: datapath operand selects.
REQ-010 SHALL have port O_IMMEDIATE, output, 16 bits: sign-extended immediate.
REQ-011 SHALL have port O_IMMEDIATE_SELECT, output, 1 bit: 1 selects the immediate as operand B.
REQ-012 SHALL have port O_OPCODE, output, 4 bits: datapath ALU opcode.
REQ-013 SHALL have port O_FLAGS, output, 5 bits: latched status flags.
REQ-014 SHALL have port O_HALTED, output, 1 bit: the FSM is in the HALT state.

Function
REQ-015 SHALL use states FETCH, DECODE, EXECUTE and HALT.
REQ-016 SHALL drive O_INSTR_READY = (state==FETCH) & I_ENABLE & ~I_RESET.
REQ-017 SHALL, when I_INSTR_VALID & O_INSTR_READY at an edge, capture I_INSTR into the instruction register and go FETCH->DECODE; with no handshake it stays in FETCH.
REQ-018 SHALL go DECODE->EXECUTE, or DECODE->HALT when the opcode is 4'hF.
REQ-019 SHALL go EXECUTE->FETCH after one enabled cycle, giving 3 cycles per instruction.
REQ-020 SHALL hold state and the instruction register while I_ENABLE=0, with O_REG_WRITE_ENABLE forced to 0.
REQ-021 SHALL decode in DECODE and EXECUTE: O_REG_A_SELECT=Rdest; O_OPCODE=opcode.
REQ-022 SHALL, for register form (IMM=0), drive O_REG_B_SELECT=Rsrc, O_IMMEDIATE_SELECT=0 and O_IMMEDIATE=0.
REQ-023 SHALL, for immediate form (IMM=1), drive O_IMMEDIATE={{9{imm7[6]}},imm7}, O_IMMEDIATE_SELECT=1 and O_REG_B_SELECT=0.
REQ-024 SHALL assert the one-hot bit Rdest of O_REG_WRITE_ENABLE only in enabled EXECUTE, and only for writing opcodes {0,4,6,7,8,9,10}.
REQ-025 SHALL treat opcode 4'hB (CMP) as: O_OPCODE=4, no write, flags still latched.
REQ-026 SHALL treat undefined opcodes as NOPs (full 3-cycle sequence, no write).
REQ-027 SHALL keep O_REG_WRITE_ENABLE=0 in FETCH, DECODE and HALT.
REQ-028 SHALL leave HALT only on reset; I_INSTR_VALID is ignored there and O_HALTED=1.

Reset
REQ-029 SHALL, while I_RESET=1, immediately force state=FETCH, instruction register=0, O_FLAGS=0 and all outputs 0.
REQ-030 SHALL abort an in-flight instruction when reset asserts mid-DECODE or mid-EXECUTE, and SHALL NOT re-issue it.

Configuration
REQ-031 SHALL, with CR16_DECODE_FLAG_LATCH_EN defined, latch I_STATUS_FLAGS into O_FLAGS at the edge ending an enabled EXECUTE for writing ops and CMP (not NOPs), and hold them otherwise.
REQ-032 SHALL, without CR16_DECODE_FLAG_LATCH_EN, tie O_FLAGS to 0 and contain no flag register.

Structure
REQ-033 SHALL place the state enum, opcode constants (ADD=0, SUB=4, AND=6, OR=7, XOR=8, NOT=9, LSH=10, CMP=11, HALT=15) and field bit positions in shared package cr16_pkg.
REQ-034 SHALL instantiate sub-module cr16_onehot_decoder (4-bit index plus enable to 16-bit one-hot) for O_REG_WRITE_ENABLE.

Verification
REQ-035 SHALL cover: reset, then I_INSTR=16'h0281 (ADD R2,imm1) valid -> two cycles after handshake O_REG_WRITE_ENABLE=16'h0004, O_IMMEDIATE=1, O_IMMEDIATE_SELECT=1, O_OPCODE=0.
REQ-036 SHALL cover: I_INSTR=16'h6301 (AND R3,R1) -> O_REG_A_SELECT=3, O_REG_B_SELECT=1, write 16'h0008 in EXECUTE only; imm7=7'h7F -> O_IMMEDIATE=16'hFFFF.
REQ-037 SHALL cover: CMP 16'hB201 -> O_OPCODE=4, O_REG_WRITE_ENABLE=0; with the macro defined, O_FLAGS equals I_STATUS_FLAGS=5'b10101 after EXECUTE.
REQ-038 SHALL cover: I_ENABLE=0 for 3 cycles during EXECUTE -> no write while low, a single write after release, state unchanged while stalled.
REQ-039 SHALL cover: 16'hF000 -> O_HALTED=1 with valid ignored for 10 cycles; I_RESET pulse -> FETCH, O_INSTR_READY=1.
REQ-040 SHALL cover: reset asserted mid-EXECUTE -> O_REG_WRITE_ENABLE drops to 0 at once and the instruction is not re-executed after release.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared CR16 decode definitions: FSM states, opcode values and instruction field positions.
// No logic and no latency; consumed by cr16_decode_fsm and its sub-modules.
// No backpressure; the package holds constants and a helper function only.
package cr16_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_LSH  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int RDEST_MSB = 11;
    localparam int RDEST_LSB = 8;
    localparam int IMM_BIT   = 7;
    localparam int IMM7_MSB  = 6;
    localparam int IMM7_LSB  = 0;
    localparam int RSRC_MSB  = 3;
    localparam int RSRC_LSB  = 0;

    function automatic logic is_write_op(input logic [3:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH: is_write_op = 1'b1;
            default:                                               is_write_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cr16_onehot_decoder.sv
// 4-bit index to 16-bit one-hot strobe, all zero when en is low.
// Combinational, zero latency.
// No backpressure; output follows inputs directly.
module cr16_onehot_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cr16_decode_fsm.sv
// CR16 fetch/decode/execute control FSM; CR16_DECODE_FLAG_LATCH_EN adds the status-flag register.
// Three enabled cycles per instruction; decode outputs follow the state/instruction registers.
// I_ENABLE=0 stalls everything and masks the write strobe; a word is accepted only in FETCH.
module cr16_decode_fsm
    import cr16_pkg::*;
(
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_ENABLE,
    input  logic        I_INSTR_VALID,
    input  logic [15:0] I_INSTR,
    input  logic [4:0]  I_STATUS_FLAGS,
    output logic        O_INSTR_READY,
    output logic [15:0] O_REG_WRITE_ENABLE,
    output logic [3:0]  O_REG_A_SELECT,
    output logic [3:0]  O_REG_B_SELECT,
    output logic [15:0] O_IMMEDIATE,
    output logic        O_IMMEDIATE_SELECT,
    output logic [3:0]  O_OPCODE,
    output logic [4:0]  O_FLAGS,
    output logic        O_HALTED
);

    state_t      state;
    logic [15:0] instr_q;

    logic [3:0] opc;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    logic [6:0] imm7;
    logic       imm_flag;
    logic       decoding;
    logic       exec_en;
    logic       wr_en;

    assign opc      = instr_q[OPC_MSB:OPC_LSB];
    assign rdest    = instr_q[RDEST_MSB:RDEST_LSB];
    assign rsrc     = instr_q[RSRC_MSB:RSRC_LSB];
    assign imm7     = instr_q[IMM7_MSB:IMM7_LSB];
    assign imm_flag = instr_q[IMM_BIT];

    assign O_INSTR_READY = (state == ST_FETCH) && I_ENABLE && !I_RESET;
    assign O_HALTED      = (state == ST_HALT);
    assign decoding      = (state == ST_DECODE) || (state == ST_EXECUTE);
    assign exec_en       = (state == ST_EXECUTE) && I_ENABLE;
    assign wr_en         = exec_en && is_write_op(opc);

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state   <= ST_FETCH;
            instr_q <= '0;
        end else if (I_ENABLE) begin
            case (state)
                ST_FETCH: begin
                    if (I_INSTR_VALID) begin
                        instr_q <= I_INSTR;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE:  state <= (opc == OP_HALT) ? ST_HALT : ST_EXECUTE;
                ST_EXECUTE: state <= ST_FETCH;
                default:    state <= ST_HALT;
            endcase
        end
    end

    // CMP reuses the SUB datapath operation without a register write.
    always_comb begin
        O_REG_A_SELECT     = '0;
        O_REG_B_SELECT     = '0;
        O_IMMEDIATE        = '0;
        O_IMMEDIATE_SELECT = 1'b0;
        O_OPCODE           = '0;
        if (decoding) begin
            O_REG_A_SELECT = rdest;
            O_OPCODE       = (opc == OP_CMP) ? OP_SUB : opc;
            if (imm_flag) begin
                O_IMMEDIATE        = {{9{imm7[6]}}, imm7};
                O_IMMEDIATE_SELECT = 1'b1;
            end else begin
                O_REG_B_SELECT = rsrc;
            end
        end
    end

    cr16_onehot_decoder u_wr_decoder (
        .idx    (rdest),
        .en     (wr_en),
        .onehot (O_REG_WRITE_ENABLE)
    );

`ifdef CR16_DECODE_FLAG_LATCH_EN
    logic [4:0] flags_q;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            flags_q <= '0;
        end else if (exec_en && (is_write_op(opc) || (opc == OP_CMP))) begin
            flags_q <= I_STATUS_FLAGS;
        end
    end

    assign O_FLAGS = flags_q;
`else
    logic unused_status_flags;
    assign unused_status_flags = ^I_STATUS_FLAGS;
    assign O_FLAGS = '0;
`endif

endmodule

// File: tb/tb_cr16_decode_fsm.sv
// Directed bench for cr16_decode_fsm: vector table of single instructions plus
// hand-written stall, halt and reset-abort sequences.
module tb_cr16_decode_fsm;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ivld;
    logic [15:0] instr;
    logic [4:0]  status;
    logic        ready;
    logic [15:0] wr;
    logic [3:0]  asel;
    logic [3:0]  bsel;
    logic [15:0] imm;
    logic        isel;
    logic [3:0]  opc;
    logic [4:0]  flags;
    logic        halted;

    int checks = 0;
    int errors = 0;

    cr16_decode_fsm dut (
        .I_CLK              (clk),
        .I_RESET            (rst),
        .I_ENABLE           (en),
        .I_INSTR_VALID      (ivld),
        .I_INSTR            (instr),
        .I_STATUS_FLAGS     (status),
        .O_INSTR_READY      (ready),
        .O_REG_WRITE_ENABLE (wr),
        .O_REG_A_SELECT     (asel),
        .O_REG_B_SELECT     (bsel),
        .O_IMMEDIATE        (imm),
        .O_IMMEDIATE_SELECT (isel),
        .O_OPCODE           (opc),
        .O_FLAGS            (flags),
        .O_HALTED           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  status;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] imm;
        logic        isel;
        logic [3:0]  op;
        logic [15:0] wr;
        logic [4:0]  flags;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_decode(input string tag, input vec_t v, input logic [15:0] exp_wr);
        check({tag, " a_sel"},   {28'd0, asel}, {28'd0, v.a});
        check({tag, " b_sel"},   {28'd0, bsel}, {28'd0, v.b});
        check({tag, " imm"},     {16'd0, imm},  {16'd0, v.imm});
        check({tag, " imm_sel"}, {31'd0, isel}, {31'd0, v.isel});
        check({tag, " opcode"},  {28'd0, opc},  {28'd0, v.op});
        check({tag, " wr_en"},   {16'd0, wr},   {16'd0, exp_wr});
    endtask

    // Starts at posedge+1 in FETCH and returns at posedge+1 back in FETCH.
    task automatic run_vec(input int idx);
        vec_t       v;
        logic [4:0] exp_flags;
        v = vecs[idx];
`ifdef CR16_DECODE_FLAG_LATCH_EN
        exp_flags = v.flags;
`else
        exp_flags = 5'd0;
`endif
        status = v.status;
        check($sformatf("v%0d fetch ready", idx), {31'd0, ready}, 32'd1);
        ivld  = 1'b1;
        instr = v.instr;
        step();
        ivld  = 1'b0;
        instr = 16'h0000;
        check_decode($sformatf("v%0d decode", idx), v, 16'h0000);
        step();
        check_decode($sformatf("v%0d execute", idx), v, v.wr);
        step();
        check($sformatf("v%0d back ready", idx), {31'd0, ready}, 32'd1);
        check($sformatf("v%0d idle wr", idx), {16'd0, wr}, 32'd0);
        check($sformatf("v%0d flags", idx), {27'd0, flags}, {27'd0, exp_flags});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nwrites;
        //          instr     status  a     b     imm       isel  op     wr        flags
        vecs[0] = '{16'h0281, 5'h01, 4'h2, 4'h0, 16'h0001, 1'b1, 4'h0, 16'h0004, 5'h01};
        vecs[1] = '{16'h6301, 5'h02, 4'h3, 4'h1, 16'h0000, 1'b0, 4'h6, 16'h0008, 5'h02};
        vecs[2] = '{16'h05FF, 5'h03, 4'h5, 4'h0, 16'hFFFF, 1'b1, 4'h0, 16'h0020, 5'h03};
        vecs[3] = '{16'hB201, 5'h15, 4'h2, 4'h1, 16'h0000, 1'b0, 4'h4, 16'h0000, 5'h15};
        vecs[4] = '{16'h4FC0, 5'h04, 4'hF, 4'h0, 16'hFFC0, 1'b1, 4'h4, 16'h8000, 5'h04};
        vecs[5] = '{16'h2A13, 5'h1F, 4'hA, 4'h3, 16'h0000, 1'b0, 4'h2, 16'h0000, 5'h04};
        vecs[6] = '{16'hA18F, 5'h06, 4'h1, 4'h0, 16'h000F, 1'b1, 4'hA, 16'h0002, 5'h06};
        vecs[7] = '{16'h8C04, 5'h07, 4'hC, 4'h4, 16'h0000, 1'b0, 4'h8, 16'h1000, 5'h07};

        rst    = 1'b1;
        en     = 1'b1;
        ivld   = 1'b1;
        instr  = 16'h0281;
        status = 5'h1F;
        step();
        step();
        check("reset ready",  {31'd0, ready},  32'd0);
        check("reset halted", {31'd0, halted}, 32'd0);
        check("reset wr",     {16'd0, wr},     32'd0);
        check("reset opcode", {28'd0, opc},    32'd0);
        check("reset flags",  {27'd0, flags},  32'd0);
        ivld = 1'b0;
        rst  = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Stall three cycles in EXECUTE of AND R3,R1.
        status = 5'h09;
        ivld   = 1'b1;
        instr  = 16'h6301;
        step();
        ivld = 1'b0;
        step();
        check("stall exec wr", {16'd0, wr}, 32'h0008);
        en = 1'b0;
        #1;
        check("stall low wr", {16'd0, wr}, 32'd0);
        nwrites = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (wr != 16'd0) nwrites++;
            check($sformatf("stall%0d a_sel", i), {28'd0, asel}, 32'd3);
            check($sformatf("stall%0d ready", i), {31'd0, ready}, 32'd0);
        end
        en = 1'b1;
        #1;
        check("stall release wr", {16'd0, wr}, 32'h0008);
        if (wr != 16'd0) nwrites++;
        step();
        if (wr != 16'd0) nwrites++;
        check("stall write count", nwrites, 32'd1);
        check("stall back ready", {31'd0, ready}, 32'd1);

        // HALT ignores further valid words until reset.
        ivld  = 1'b1;
        instr = 16'hF000;
        step();
        check("halt decode opcode", {28'd0, opc}, 32'hF);
        instr = 16'h0281;
        step();
        nwrites = 0;
        for (int i = 0; i < 10; i++) begin
            if (halted !== 1'b1 || ready !== 1'b0 || wr != 16'd0) nwrites++;
            step();
        end
        check("halt held", nwrites, 32'd0);
        check("halt halted", {31'd0, halted}, 32'd1);
        ivld = 1'b0;
        rst  = 1'b1;
        #1;
        check("halt reset halted", {31'd0, halted}, 32'd0);
        check("halt reset ready",  {31'd0, ready},  32'd0);
        step();
        rst = 1'b0;
        #1;
        check("halt release ready", {31'd0, ready}, 32'd1);
        step();

        // Reset mid-EXECUTE aborts the instruction for good.
        ivld  = 1'b1;
        instr = 16'h0281;
        step();
        ivld = 1'b0;
        step();
        check("abort exec wr", {16'd0, wr}, 32'h0004);
        rst = 1'b1;
        #1;
        check("abort wr drop", {16'd0, wr},     32'd0);
        check("abort a_sel",   {28'd0, asel},   32'd0);
        check("abort flags",   {27'd0, flags},  32'd0);
        step();
        rst = 1'b0;
        nwrites = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wr != 16'd0 || ready !== 1'b1) nwrites++;
        end
        check("abort no reissue", nwrites, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
